// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, receiver states, default divider.
// Imported by the baud tick generator and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      WAIT_HI
   } rx_state_t;

   localparam int unsigned BAUD_DIV_DEF = 2604;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate down counter: half-bit preload on start, full-bit reload per tick.
// Intended to be shared by RX and a future TX.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_half,
   input  logic run,
   output logic tick
);

   localparam int W = $clog2(BAUD_DIV);
   localparam logic [W-1:0] HALF = W'(BAUD_DIV / 2 - 1);
   localparam logic [W-1:0] FULL = W'(BAUD_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load_half) begin
         cnt <= HALF;
      end else if (run) begin
         if (cnt == '0) cnt <= FULL;
         else           cnt <= cnt - 1'b1;
      end
   end

   assign tick = run && (cnt == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: width, parity, stop bits, false-start
// rejection, framing/parity/overrun flags with consumer acknowledge.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV  = BAUD_DIV_DEF,
   parameter int unsigned DATA_BITS = 8,
   parameter parity_t     PARITY    = PAR_NONE,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX,
   input  logic                 clr_rdy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdy,
   output logic                 par_err,
   output logic                 frm_err,
   output logic                 ovr_err
);

   localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);

   rx_state_t            state, state_nx;
   logic                 sync1, rx_s;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] sh;
   logic                 par_acc, frm_acc;
   logic                 tick, load_half, run, done, frm_now;

   uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_half (load_half),
      .run       (run),
      .tick      (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
         state <= IDLE;
      end else begin
         sync1 <= RX;
         rx_s  <= sync1;
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      load_half = 1'b0;
      run       = 1'b0;
      done      = 1'b0;
      frm_now   = frm_acc | ~rx_s;
      unique case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nx  = START;
               load_half = 1'b1;
            end
         end
         START: begin
            run = 1'b1;
            if (tick) state_nx = rx_s ? IDLE : DATA;
         end
         DATA: begin
            run = 1'b1;
            if (tick && bit_cnt == DB_LAST)
               state_nx = (PARITY != PAR_NONE) ? PAR : STOP;
         end
         PAR: begin
            run = 1'b1;
            if (tick) state_nx = STOP;
         end
         STOP: begin
            run = 1'b1;
            if (tick && bit_cnt == SB_LAST) begin
               done     = 1'b1;
               state_nx = frm_now ? WAIT_HI : IDLE;
            end
         end
         WAIT_HI: begin
            if (rx_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         sh      <= '0;
         par_acc <= 1'b0;
         frm_acc <= 1'b0;
      end else if (tick) begin
         unique case (state)
            START: begin
               bit_cnt <= '0;
               par_acc <= 1'b0;
               frm_acc <= 1'b0;
            end
            DATA: begin
               sh      <= {rx_s, sh[DATA_BITS-1:1]};
               bit_cnt <= (bit_cnt == DB_LAST) ? 4'd0 : bit_cnt + 4'd1;
            end
            PAR: par_acc <= (^{sh, rx_s}) != (PARITY == PAR_ODD);
            STOP: begin
               frm_acc <= frm_now;
               bit_cnt <= bit_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // A completing frame beats a same-cycle ack: the ack frees the slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data <= '0;
         rdy     <= 1'b0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
         ovr_err <= 1'b0;
      end else if (done) begin
         if (!rdy || clr_rdy) begin
            rx_data <= sh;
            par_err <= par_acc;
            frm_err <= frm_now;
            rdy     <= 1'b1;
            ovr_err <= 1'b0;
         end else begin
            ovr_err <= 1'b1;
         end
      end else if (clr_rdy) begin
         rdy     <= 1'b0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
         ovr_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2)
// sharing clock and reset, each with its own serial line and ack.
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] rx_v, clr_v, rdy_v, pe_v, fe_v, oe_v;
   logic [7:0] d0_q;
   logic [6:0] d1_q;
   logic [7:0] d2_q;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         d;
      logic [8:0] data;
      logic       pe;
      logic       fe;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   uart_rx_cfg #(.BAUD_DIV(BD)) d0 (
      .clk(clk), .rst_n(rst_n), .RX(rx_v[0]), .clr_rdy(clr_v[0]),
      .rx_data(d0_q), .rdy(rdy_v[0]), .par_err(pe_v[0]),
      .frm_err(fe_v[0]), .ovr_err(oe_v[0])
   );

   uart_rx_cfg #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(PAR_EVEN)) d1 (
      .clk(clk), .rst_n(rst_n), .RX(rx_v[1]), .clr_rdy(clr_v[1]),
      .rx_data(d1_q), .rdy(rdy_v[1]), .par_err(pe_v[1]),
      .frm_err(fe_v[1]), .ovr_err(oe_v[1])
   );

   uart_rx_cfg #(.BAUD_DIV(BD), .STOP_BITS(2)) d2 (
      .clk(clk), .rst_n(rst_n), .RX(rx_v[2]), .clr_rdy(clr_v[2]),
      .rx_data(d2_q), .rdy(rdy_v[2]), .par_err(pe_v[2]),
      .frm_err(fe_v[2]), .ovr_err(oe_v[2])
   );

   function automatic logic [8:0] dat(int d);
      case (d)
         0:       return {1'b0, d0_q};
         1:       return {2'b0, d1_q};
         default: return {1'b0, d2_q};
      endcase
   endfunction

   function automatic logic even_err(logic [8:0] data, int nb, int pbit);
      logic x;
      x = pbit[0];
      for (int i = 0; i < nb; i++) x ^= data[i];
      return x;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(int d, logic [8:0] data, logic pe, logic fe);
      exp_t e;
      e.d    = d;
      e.data = data;
      e.pe   = pe;
      e.fe   = fe;
      sb.push_back(e);
   endtask

   // start bit, nb data bits LSB first, optional parity, ns stop bits
   task automatic send(int d, logic [8:0] data, int nb, int pbit,
                       logic [1:0] stops, int ns, int nsend);
      logic [15:0] v;
      int n;
      v    = '0;
      n    = 1;
      for (int i = 0; i < nb; i++) begin v[n] = data[i]; n++; end
      if (pbit >= 0) begin v[n] = pbit[0]; n++; end
      for (int i = 0; i < ns; i++) begin v[n] = stops[i]; n++; end
      if (nsend > 0 && nsend < n) n = nsend;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_v[d] = v[i];
         repeat (BD - 1) @(negedge clk);
      end
   endtask

   task automatic expect_word(string tag);
      exp_t e;
      int k;
      if (sb.size() == 0) begin
         check($sformatf("%s sb empty", tag), 1, 0);
         return;
      end
      e = sb.pop_front();
      k = 0;
      while (!rdy_v[e.d] && k < 400) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("%s rdy", tag), rdy_v[e.d], 1);
      check($sformatf("%s data", tag), dat(e.d), e.data);
      check($sformatf("%s par_err", tag), pe_v[e.d], e.pe);
      check($sformatf("%s frm_err", tag), fe_v[e.d], e.fe);
   endtask

   task automatic ack(int d, string tag);
      @(negedge clk);
      clr_v[d] = 1'b1;
      @(negedge clk);
      clr_v[d] = 1'b0;
      check($sformatf("%s ack rdy", tag), rdy_v[d], 0);
      check($sformatf("%s ack flags", tag),
            {pe_v[d], fe_v[d], oe_v[d]}, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n = 1'b0;
      rx_v  = '1;
      clr_v = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst data%0d", d), dat(d), 0);
         check($sformatf("rst flags%0d", d),
               {rdy_v[d], pe_v[d], fe_v[d], oe_v[d]}, 0);
      end
      rst_n = 1'b1;
      repeat (BD) @(negedge clk);

      // 8N1 word and start-to-ready latency
      push(0, 9'hA5, 1'b0, 1'b0);
      lat = 0;
      fork
         send(0, 9'hA5, 8, -1, 2'b11, 1, 0);
         begin
            while (!rdy_v[0] && lat < 400) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check("t1 latency", (lat >= 152 && lat <= 166), 1);
      expect_word("t1");
      check("t1 ovr", oe_v[0], 0);
      ack(0, "t1");

      // 7E1 with wrong then correct parity
      push(1, 9'h3C, even_err(9'h3C, 7, 1), 1'b0);
      send(1, 9'h3C, 7, 1, 2'b11, 1, 0);
      expect_word("t2 bad");
      ack(1, "t2 bad");
      push(1, 9'h3C, even_err(9'h3C, 7, 0), 1'b0);
      send(1, 9'h3C, 7, 0, 2'b11, 1, 0);
      expect_word("t2 good");
      ack(1, "t2 good");

      // 8N2 second stop low, line held low, then clean frame
      push(2, 9'hC3, 1'b0, 1'b1);
      send(2, 9'hC3, 8, -1, 2'b01, 2, 0);
      repeat (100) @(negedge clk);
      expect_word("t3 brk");
      ack(2, "t3 brk");
      repeat (100) @(negedge clk);
      check("t3 no restart", rdy_v[2], 0);
      rx_v[2] = 1'b1;
      repeat (2 * BD) @(negedge clk);
      push(2, 9'h55, 1'b0, 1'b0);
      send(2, 9'h55, 8, -1, 2'b11, 2, 0);
      expect_word("t3 55");
      check("t3 ovr", oe_v[2], 0);
      ack(2, "t3 55");

      // short low glitch rejected at mid-start
      @(negedge clk);
      rx_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      rx_v[0] = 1'b1;
      repeat (12 * BD) @(negedge clk);
      check("t4 glitch", {rdy_v[0], pe_v[0], fe_v[0], oe_v[0]}, 0);
      push(0, 9'h5A, 1'b0, 1'b0);
      send(0, 9'h5A, 8, -1, 2'b11, 1, 0);
      expect_word("t4 5A");
      ack(0, "t4 5A");

      // overrun, then ack coincident with third completion
      push(0, 9'h11, 1'b0, 1'b0);
      send(0, 9'h11, 8, -1, 2'b11, 1, 0);
      expect_word("t5 11");
      send(0, 9'h22, 8, -1, 2'b11, 1, 0);
      check("t5 ovr data", dat(0), 9'h11);
      check("t5 ovr flag", oe_v[0], 1);
      check("t5 ovr rdy", rdy_v[0], 1);
      push(0, 9'h33, 1'b0, 1'b0);
      fork
         send(0, 9'h33, 8, -1, 2'b11, 1, 0);
         begin
            repeat (155) @(negedge clk);
            clr_v[0] = 1'b1;
            @(negedge clk);
            clr_v[0] = 1'b0;
         end
      join
      expect_word("t5 33");
      check("t5 ovr cleared", oe_v[0], 0);

      // reset mid-DATA with a word pending
      send(0, 9'hF0, 8, -1, 2'b11, 1, 4);
      @(negedge clk);
      rst_n   = 1'b0;
      rx_v[0] = 1'b1;
      @(negedge clk);
      check("t6 rst data", dat(0), 0);
      check("t6 rst flags", {rdy_v[0], pe_v[0], fe_v[0], oe_v[0]}, 0);
      rst_n = 1'b1;
      repeat (2 * BD) @(negedge clk);
      push(0, 9'hF0, 1'b0, 1'b0);
      send(0, 9'hF0, 8, -1, 2'b11, 1, 0);
      expect_word("t6 F0");
      check("t6 ovr", oe_v[0], 0);
      check("sb drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
